lif_param_sequencer: RTL and testbench
======================================

Name: lif_param_sequencer

Overview:
- Controller that configures the LIF neuron datapath at run time.
- Accepts a parallel parameter set (weight, leak_config, threshold) through a valid/ready handshake, serializes it onto the loader's load_mode/serial_data pins, then waits for the loader's params_ready.
- Mutes the neuron's chan_a input while reconfiguration is in progress.
- Sits between the host/test logic and lif_neuron_system.

Parameters:
- FRAME_BITS, 13: serialized frame length (3 weight + 2 leak + 8 threshold).
- TIMEOUT_CYC, 32: max cycles spent in WAIT_RDY before flagging an error.
- MAX_RETRY, 2: retries after timeout (used only with LIF_SEQ_RETRY_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  system enable, shared with the loader; shifting advances only when high.
- cfg_valid  in  1  parameter set offered.
- cfg_ready  out  1  sequencer can accept a set.
- cfg_weight  in  3  weight.
- cfg_leak  in  2  leak_config.
- cfg_threshold  in  8  threshold.
- chan_a_in  in  6  raw input channel.
- chan_a_out  out  6  gated channel to the neuron.
- load_mode  out  1  to loader load_enable.
- serial_data  out  1  to loader serial_data_in.
- params_ready  in  1  from loader.
- busy  out  1  reconfiguration in progress.
- done  out  1  one-cycle pulse on successful load.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset values: cfg_ready=0, load_mode=0, serial_data=0, busy=0, done=0, err=0, state=IDLE, all counters and the shift register 0. chan_a_out follows its combinational rule below (reset state is IDLE).
- States: IDLE, SHIFT, WAIT_RDY, DONE.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid&&cfg_ready, latch {cfg_weight, cfg_leak, cfg_threshold} into shift_reg (weight in the MSBs), clear err, clear bit_cnt and dropped flag, go to SHIFT.
  - cfg_ready is registered and low in every other state.
- SHIFT:
  - load_mode=1; serial_data=shift_reg[FRAME_BITS-1] (MSB first: weight[2], …, threshold[0]).
  - On each cycle with enable=1: shift left by one and increment bit_cnt.
  - With enable=0: hold everything, load_mode stays 1.
  - After the bit with bit_cnt==FRAME_BITS-1 is presented with enable=1, go to WAIT_RDY.
  - Exactly FRAME_BITS enabled cycles have load_mode=1.
- WAIT_RDY:
  - load_mode=0, serial_data=0; tmo_cnt increments each cycle regardless of enable.
  - Set dropped when params_ready==0 is sampled in SHIFT or WAIT_RDY.
  - Success when params_ready==1 && dropped==1: go to DONE. This prevents accepting a stale ready from the previous load.
  - If tmo_cnt reaches TIMEOUT_CYC-1 without success: set err=1, go to IDLE.
  - If success and timeout occur in the same cycle, success wins.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in SHIFT, WAIT_RDY and DONE.
- chan_a_out: combinational, = busy ? 6'd0 : chan_a_in.
- Latency: a new set accepted at cycle T with enable continuously high gives load_mode high for T+1..T+13. done is asserted no earlier than T+15.
- cfg_valid while busy is ignored; the upstream must hold it until accepted.
- Reset asserted mid-frame: immediate return to reset values, load_mode drops asynchronously. The partial frame is discarded, and the loader is expected to reject the truncated frame.

Optional Feature:
- Macro: LIF_SEQ_RETRY_EN.
- Defined: on timeout, if retry_cnt < MAX_RETRY, increment retry_cnt, reload shift_reg from the latched copy of the parameter set, clear bit_cnt, tmo_cnt and dropped, and re-enter SHIFT. err is set only after the final retry times out. retry_cnt clears on each accept.
- Undefined: there is no latched copy and no retry_cnt; timeout goes directly to err and IDLE.

Decomposition:
- Shared package lif_pkg:
  - widths WEIGHT_W=3, LEAK_W=2, THRESH_W=8, CHAN_W=6, FRAME_BITS.
  - state enum typedef.
  - function packing {weight, leak, threshold} into a frame.
- One natural sub-module, lif_frame_serializer: shift register, bit counter and enable-gated advance, with start/last handshake to the FSM.

Test Plan:
- Reset then accept weight=3'b101, leak=2'b10, threshold=8'hA5 with enable=1 → load_mode high 13 cycles, serial_data = 1,0,1,1,0,1,0,1,0,0,1,0,1. Model params_ready low during the frame and high 2 cycles after it → done pulses once, err=0, cfg_ready returns to 1.
- Same frame with enable low for 4 cycles at bit 5 → load_mode held high, bit 5 repeated for 4 cycles, 13 enabled shift cycles total, same serial sequence.
- params_ready stuck high (never drops) → no done; err=1 after 32 WAIT_RDY cycles, back to IDLE. With LIF_SEQ_RETRY_EN, 3 frames are emitted before err=1.
- chan_a_in=6'h2A throughout a load → chan_a_out=0 while busy, 6'h2A in IDLE.
- Reset asserted at bit 7 → load_mode, busy and cfg_ready go 0 immediately. After release, a fresh frame is accepted and completes normally.
- cfg_valid pulsed during WAIT_RDY with a different set → ignored; the loaded frame matches the first set.

Source files
------------

// File: rtl/lif_pkg.sv
// ============================================================================
// Module      : lif_pkg
// Description : Shared widths, sequencer state encoding and frame packing for
//               the LIF parameter sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package lif_pkg;

    localparam int WEIGHT_W   = 3;
    localparam int LEAK_W     = 2;
    localparam int THRESH_W   = 8;
    localparam int CHAN_W     = 6;
    localparam int FRAME_BITS = WEIGHT_W + LEAK_W + THRESH_W;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_WAIT_RDY = 2'd2,
        ST_DONE     = 2'd3
    } seq_state_e;

    // Weight lands in the MSBs so it is the first field on the wire.
    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic [WEIGHT_W-1:0] weight,
        input logic [LEAK_W-1:0]   leak,
        input logic [THRESH_W-1:0] threshold
    );
        return {weight, leak, threshold};
    endfunction

endpackage

`default_nettype wire

// File: rtl/lif_frame_serializer.sv
// ============================================================================
// Module      : lif_frame_serializer
// Description : MSB-first frame shifter with bit counter; advances only on
//               enabled cycles while active, flags the final bit.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lif_frame_serializer
    import lif_pkg::*;
#(
    parameter int WIDTH = FRAME_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic             i_start,
    input  logic             i_active,
    input  logic [WIDTH-1:0] i_frame,
    output logic             o_serial_bit,
    output logic             o_last
);

    localparam int               CNT_W       = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST_IDX  = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (i_start) begin
            shift_d   = i_frame;
            bit_cnt_d = '0;
        end else if (i_active && i_enable) begin
            shift_d   = {shift_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign o_serial_bit = i_active ? shift_q[WIDTH-1] : 1'b0;
    assign o_last       = i_active && i_enable && (bit_cnt_q == c_LAST_IDX);

endmodule

`default_nettype wire

// File: rtl/lif_param_sequencer.sv
// ============================================================================
// Module      : lif_param_sequencer
// Description : Accepts a LIF parameter set, serializes it to the loader,
//               waits for a fresh params_ready and mutes chan_a meanwhile.
//               Optional timeout retry enabled by macro LIF_SEQ_RETRY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lif_param_sequencer #(
    parameter int FRAME_BITS  = 13,
    parameter int TIMEOUT_CYC = 32,
    parameter int MAX_RETRY   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [lif_pkg::WEIGHT_W-1:0]  cfg_weight,
    input  logic [lif_pkg::LEAK_W-1:0]    cfg_leak,
    input  logic [lif_pkg::THRESH_W-1:0]  cfg_threshold,
    input  logic [lif_pkg::CHAN_W-1:0]    chan_a_in,
    output logic [lif_pkg::CHAN_W-1:0]    chan_a_out,
    output logic                          load_mode,
    output logic                          serial_data,
    input  logic                          params_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    import lif_pkg::*;

    localparam int               TMO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    seq_state_e            state_q, state_d;
    logic                  cfg_ready_q, cfg_ready_d;
    logic                  err_q, err_d;
    logic                  dropped_q, dropped_d;
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;

    logic                  w_accept;
    logic                  w_start;
    logic                  w_last;
    logic                  w_serial;
    logic                  w_shifting;
    logic [FRAME_BITS-1:0] w_frame;

`ifdef LIF_SEQ_RETRY_EN
    localparam int                 RETRY_W     = $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] c_MAX_RETRY = RETRY_W'(MAX_RETRY);

    logic [RETRY_W-1:0]    retry_cnt_q, retry_cnt_d;
    logic [FRAME_BITS-1:0] cfg_frame_q, cfg_frame_d;
`endif

    assign w_accept   = cfg_valid && cfg_ready_q;
    assign w_shifting = (state_q == ST_SHIFT);

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        dropped_d = dropped_q;
        tmo_cnt_d = '0;
        w_start   = 1'b0;
        w_frame   = FRAME_BITS'(pack_frame(cfg_weight, cfg_leak, cfg_threshold));
`ifdef LIF_SEQ_RETRY_EN
        retry_cnt_d = retry_cnt_q;
        cfg_frame_d = cfg_frame_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d   = ST_SHIFT;
                    err_d     = 1'b0;
                    dropped_d = 1'b0;
                    w_start   = 1'b1;
`ifdef LIF_SEQ_RETRY_EN
                    retry_cnt_d = '0;
                    cfg_frame_d = w_frame;
`endif
                end
            end
            ST_SHIFT: begin
                if (!params_ready) dropped_d = 1'b1;
                if (w_last)        state_d   = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (!params_ready) dropped_d = 1'b1;
                // A ready that never dropped belongs to the previous load.
                if (params_ready && dropped_q) begin
                    state_d = ST_DONE;
                end else if (tmo_cnt_q == c_TMO_LAST) begin
`ifdef LIF_SEQ_RETRY_EN
                    if (retry_cnt_q < c_MAX_RETRY) begin
                        retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                        w_frame     = cfg_frame_q;
                        w_start     = 1'b1;
                        dropped_d   = 1'b0;
                        tmo_cnt_d   = '0;
                        state_d     = ST_SHIFT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
`else
                    // Without retry any retry depth gives up on the first timeout.
                    if (MAX_RETRY >= 0) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cfg_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cfg_ready_q <= 1'b0;
            err_q       <= 1'b0;
            dropped_q   <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= cfg_ready_d;
            err_q       <= err_d;
            dropped_q   <= dropped_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

`ifdef LIF_SEQ_RETRY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retry_cnt_q <= '0;
            cfg_frame_q <= '0;
        end else begin
            retry_cnt_q <= retry_cnt_d;
            cfg_frame_q <= cfg_frame_d;
        end
    end
`endif

    lif_frame_serializer #(
        .WIDTH (FRAME_BITS)
    ) u_serializer (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (enable),
        .i_start      (w_start),
        .i_active     (w_shifting),
        .i_frame      (w_frame),
        .o_serial_bit (w_serial),
        .o_last       (w_last)
    );

    assign cfg_ready   = cfg_ready_q;
    assign load_mode   = w_shifting;
    assign serial_data = w_serial;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign err         = err_q;
    assign chan_a_out  = busy ? '0 : chan_a_in;

endmodule

`default_nettype wire

// File: tb/tb_lif_param_sequencer.sv
// ============================================================================
// Module      : tb_lif_param_sequencer
// Description : Scoreboard bench for lif_param_sequencer with a simple
//               loader model driving params_ready.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lif_param_sequencer;

    localparam int TIMEOUT_CYC = 32;
`ifdef LIF_SEQ_RETRY_EN
    localparam int N_FRAMES_TMO = 3;
`else
    localparam int N_FRAMES_TMO = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [2:0] cfg_weight = '0;
    logic [1:0] cfg_leak = '0;
    logic [7:0] cfg_threshold = '0;
    logic [5:0] chan_a_in = 6'h2A;
    logic       params_ready = 1'b1;
    logic       cfg_ready, load_mode, serial_data, busy, done, err;
    logic [5:0] chan_a_out;

    int checks = 0;
    int failures = 0;
    bit exp_bits[$];
    int done_cnt = 0;
    int en_cycles = 0;
    int hold_cycles = 0;
    bit done_prev = 1'b0;
    bit ready_stuck = 1'b0;
    int pr_cnt = 0;

    always #5 clk = ~clk;

    lif_param_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_weight    (cfg_weight),
        .cfg_leak      (cfg_leak),
        .cfg_threshold (cfg_threshold),
        .chan_a_in     (chan_a_in),
        .chan_a_out    (chan_a_out),
        .load_mode     (load_mode),
        .serial_data   (serial_data),
        .params_ready  (params_ready),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Loader model: ready drops while a frame is loading, returns 2 cycles later.
    always @(negedge clk) begin
        if (ready_stuck) begin
            params_ready = 1'b1;
        end else if (load_mode) begin
            params_ready = 1'b0;
            pr_cnt = 0;
        end else if (!params_ready) begin
            pr_cnt++;
            if (pr_cnt >= 2) params_ready = 1'b1;
        end
    end

    // Monitor: compares each presented bit with the scoreboard head.
    always @(negedge clk) begin
        bit b;
        if (load_mode) begin
            if (exp_bits.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_bit: serial_data=%0b presented, no bit expected", serial_data);
            end else begin
                check("serial_bit", {31'd0, serial_data}, {31'd0, exp_bits[0]});
                if (enable) begin
                    b = exp_bits.pop_front();
                    en_cycles++;
                end else begin
                    hold_cycles++;
                end
            end
            check("chan_mute_shift", {26'd0, chan_a_out}, 32'd0);
        end
        if (done) begin
            check("done_single_pulse", {31'd0, done_prev}, 32'd0);
            done_cnt++;
        end
        done_prev = done;
    end

    task automatic push_frame(input logic [2:0] w, input logic [1:0] l, input logic [7:0] t);
        logic [12:0] f;
        f = {w, l, t};
        for (int i = 12; i >= 0; i--) exp_bits.push_back(f[i]);
    endtask

    task automatic send_cfg(input logic [2:0] w, input logic [1:0] l, input logic [7:0] t);
        int n;
        n = 0;
        @(negedge clk);
        while (!cfg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: cfg_ready=0 after %0d cycles, required 1", n);
        end
        push_frame(w, l, t);
        cfg_weight    = w;
        cfg_leak      = l;
        cfg_threshold = t;
        cfg_valid     = 1'b1;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        int start;
        n = 0;
        start = done_cnt;
        while (done_cnt == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(name, done_cnt - start, 32'd1);
    endtask

    task automatic wait_load(input logic want, input string name);
        int n;
        n = 0;
        while (load_mode !== want && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, load_mode}, {31'd0, want});
    endtask

    initial begin
        int cnt;
        int d0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        check("rst_load_mode", {31'd0, load_mode}, 32'd0);
        check("rst_serial", {31'd0, serial_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_chan", {26'd0, chan_a_out}, 32'h2A);
        reset = 1'b1;
        @(negedge clk);
        check("idle_cfg_ready", {31'd0, cfg_ready}, 32'd1);

        // Basic load
        en_cycles = 0;
        send_cfg(3'b101, 2'b10, 8'hA5);
        wait_done("basic_done", 100);
        check("basic_en_cycles", en_cycles, 32'd13);
        check("basic_bits_left", exp_bits.size(), 32'd0);
        check("basic_err", {31'd0, err}, 32'd0);
        check("basic_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("basic_busy", {31'd0, busy}, 32'd0);
        check("chan_idle", {26'd0, chan_a_out}, 32'h2A);

        // Enable stall at bit 5
        en_cycles = 0;
        hold_cycles = 0;
        send_cfg(3'b101, 2'b10, 8'hA5);
        repeat (5) @(posedge clk);
        #1 enable = 1'b0;
        repeat (4) @(posedge clk);
        #1 enable = 1'b1;
        wait_done("stall_done", 100);
        check("stall_hold_cycles", hold_cycles, 32'd4);
        check("stall_en_cycles", en_cycles, 32'd13);
        check("stall_bits_left", exp_bits.size(), 32'd0);

        // Stale ready never drops: timeout
        ready_stuck = 1'b1;
        en_cycles = 0;
        d0 = done_cnt;
        send_cfg(3'b010, 2'b01, 8'h0F);
        for (int i = 1; i < N_FRAMES_TMO; i++) push_frame(3'b010, 2'b01, 8'h0F);
        for (int i = 0; i < N_FRAMES_TMO; i++) begin
            wait_load(1'b1, "tmo_frame_start");
            wait_load(1'b0, "tmo_frame_end");
            if (i < N_FRAMES_TMO - 1) check("tmo_err_early", {31'd0, err}, 32'd0);
        end
        cnt = 0;
        while (!err && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("tmo_wait_cycles", cnt, TIMEOUT_CYC);
        check("tmo_err", {31'd0, err}, 32'd1);
        check("tmo_no_done", done_cnt - d0, 32'd0);
        check("tmo_en_cycles", en_cycles, 13 * N_FRAMES_TMO);
        check("tmo_busy", {31'd0, busy}, 32'd0);
        check("tmo_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        ready_stuck = 1'b0;

        // cfg_valid during WAIT_RDY is ignored; accept clears err
        en_cycles = 0;
        send_cfg(3'b011, 2'b01, 8'h3C);
        check("accept_clears_err", {31'd0, err}, 32'd0);
        wait_load(1'b1, "ign_frame_start");
        wait_load(1'b0, "ign_frame_end");
        check("chan_mute_wait", {26'd0, chan_a_out}, 32'd0);
        check("wait_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        cfg_weight    = 3'b110;
        cfg_leak      = 2'b11;
        cfg_threshold = 8'hC3;
        cfg_valid     = 1'b1;
        repeat (2) @(posedge clk);
        #1 cfg_valid = 1'b0;
        wait_done("ign_done", 100);
        repeat (5) @(negedge clk);
        check("ign_en_cycles", en_cycles, 32'd13);
        check("ign_busy", {31'd0, busy}, 32'd0);

        // Reset mid-frame
        send_cfg(3'b110, 2'b11, 8'h5A);
        repeat (7) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst_load_mode", {31'd0, load_mode}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        check("midrst_serial", {31'd0, serial_data}, 32'd0);
        exp_bits.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        en_cycles = 0;
        send_cfg(3'b101, 2'b10, 8'hA5);
        wait_done("postrst_done", 100);
        check("postrst_en_cycles", en_cycles, 32'd13);
        check("postrst_err", {31'd0, err}, 32'd0);
        check("postrst_bits_left", exp_bits.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000ns, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
